// File: rtl/euler_sched_pkg.sv
// Shared types and constants for the quaternion-to-Euler converter scheduler.
package euler_sched_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      HOLD
   } sched_state_t;

   typedef struct packed {
      logic signed [31:0] w;
      logic signed [31:0] x;
      logic signed [31:0] y;
      logic signed [31:0] z;
   } quat_t;

   typedef struct packed {
      logic signed [31:0] roll;
      logic signed [31:0] pitch;
      logic signed [31:0] yaw;
   } euler_t;

   localparam logic SRC_ROT  = 1'b0;
   localparam logic SRC_GAME = 1'b1;

   localparam int TIMER_W = 16;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [TIMER_W-1:0] sat_inc(input logic [TIMER_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter: on a tie the requester that was not
// granted last time wins; a lone requester always wins. Purely combinational.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   input  logic       en,
   output logic [1:0] grant
);

   // One-hot grant selection, suppressed entirely when not enabled.
   always_comb begin
      grant = 2'b00;
      if (en) begin
         if (req == 2'b11) begin
            grant = last ? 2'b01 : 2'b10;
         end else begin
            grant = req;
         end
      end
   end

endmodule

// File: rtl/euler_conv_scheduler.sv
// Schedules the shared quaternion-to-Euler converter between the rotation-vector
// (source 0) and game-rotation-vector (source 1) producers. One sample is in
// flight at a time: accept, start the converter, wait for done (with timeout),
// then hold the result on a valid/ready output until taken.
// Optional build macro CONV_STATS_EN adds saturating conv_count/timeout_count.
module euler_conv_scheduler
   import euler_sched_pkg::*;
#(
   parameter int TIMEOUT_CYC = 64
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         s0_valid,
   output logic         s0_ready,
   input  logic [127:0] s0_quat,
   input  logic         s1_valid,
   output logic         s1_ready,
   input  logic [127:0] s1_quat,
   output logic         conv_start,
   output logic [31:0]  conv_w,
   output logic [31:0]  conv_x,
   output logic [31:0]  conv_y,
   output logic [31:0]  conv_z,
   input  logic         conv_done,
   input  logic [31:0]  conv_roll,
   input  logic [31:0]  conv_pitch,
   input  logic [31:0]  conv_yaw,
   output logic         m_valid,
   input  logic         m_ready,
   output logic [31:0]  m_roll,
   output logic [31:0]  m_pitch,
   output logic [31:0]  m_yaw,
   output logic         m_src,
`ifdef CONV_STATS_EN
   output logic [15:0]  conv_count,
   output logic [15:0]  timeout_count,
`endif
   output logic         busy,
   output logic         timeout_err
);

   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYC - 1);

   sched_state_t       state_reg;
   logic               rr_last_reg;
   logic [TIMER_W-1:0] timer_reg;
   logic [1:0]         grant;
   logic               handshake;
   logic               done_hit;
   logic               timeout_hit;
   quat_t              sel_quat;

   rr_arb2 u_arb (
      .req   ({s1_valid, s0_valid}),
      .last  (rr_last_reg),
      .en    (state_reg == IDLE),
      .grant (grant)
   );

   // Ready is the arbiter grant itself, so it follows valid within the cycle.
   assign s0_ready  = grant[0];
   assign s1_ready  = grant[1];
   assign handshake = |grant;
   assign sel_quat  = quat_t'(grant[1] ? s1_quat : s0_quat);

   // A done on the last allowed WAIT cycle still counts, so timeout requires !conv_done.
   assign done_hit    = (state_reg == WAIT) && conv_done;
   assign timeout_hit = (state_reg == WAIT) && !conv_done && (timer_reg == TIMER_LAST);
   assign timeout_err = timeout_hit;
   assign busy        = (state_reg != IDLE);

   // Scheduler FSM with registered converter and result outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         rr_last_reg <= 1'b1;
         timer_reg   <= '0;
         conv_start  <= 1'b0;
         conv_w      <= '0;
         conv_x      <= '0;
         conv_y      <= '0;
         conv_z      <= '0;
         m_valid     <= 1'b0;
         m_roll      <= '0;
         m_pitch     <= '0;
         m_yaw       <= '0;
         m_src       <= 1'b0;
      end else begin
         conv_start <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (handshake) begin
                  conv_w      <= sel_quat.w;
                  conv_x      <= sel_quat.x;
                  conv_y      <= sel_quat.y;
                  conv_z      <= sel_quat.z;
                  m_src       <= grant[1] ? SRC_GAME : SRC_ROT;
                  rr_last_reg <= grant[1];
                  conv_start  <= 1'b1;
                  state_reg   <= ISSUE;
               end
            end
            ISSUE: begin
               timer_reg <= '0;
               state_reg <= WAIT;
            end
            WAIT: begin
               if (done_hit) begin
                  m_roll    <= conv_roll;
                  m_pitch   <= conv_pitch;
                  m_yaw     <= conv_yaw;
                  m_valid   <= 1'b1;
                  state_reg <= HOLD;
               end else if (timeout_hit) begin
                  state_reg <= IDLE;
               end else begin
                  timer_reg <= sat_inc(timer_reg);
               end
            end
            HOLD: begin
               if (m_ready) begin
                  m_valid   <= 1'b0;
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

`ifdef CONV_STATS_EN
   // Saturating counts of accepted conversions and abandoned conversions.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         conv_count    <= '0;
         timeout_count <= '0;
      end else begin
         if (done_hit) begin
            conv_count <= sat_inc(conv_count);
         end
         if (timeout_hit) begin
            timeout_count <= sat_inc(timeout_count);
         end
      end
   end
`endif

endmodule

// File: tb/tb_euler_conv_scheduler.sv
// Self-checking bench for euler_conv_scheduler: a transaction/timestamp model
// predicts every output each cycle, plus directed literal checks per scenario.
// Build with CONV_STATS_EN defined to also cover the statistics counters.
module tb_euler_conv_scheduler;

   localparam int T = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         s0_valid, s0_ready, s1_valid, s1_ready;
   logic [127:0] s0_quat, s1_quat;
   logic         conv_start;
   logic [31:0]  conv_w, conv_x, conv_y, conv_z;
   logic         conv_done;
   logic [31:0]  conv_roll, conv_pitch, conv_yaw;
   logic         m_valid, m_ready;
   logic [31:0]  m_roll, m_pitch, m_yaw;
   logic         m_src;
   logic         busy, timeout_err;
`ifdef CONV_STATS_EN
   logic [15:0]  conv_count, timeout_count;
`endif

   always #5 clk = ~clk;

   euler_conv_scheduler #(.TIMEOUT_CYC(T)) dut (
      .clk(clk), .rst_n(rst_n),
      .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_quat(s0_quat),
      .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_quat(s1_quat),
      .conv_start(conv_start),
      .conv_w(conv_w), .conv_x(conv_x), .conv_y(conv_y), .conv_z(conv_z),
      .conv_done(conv_done),
      .conv_roll(conv_roll), .conv_pitch(conv_pitch), .conv_yaw(conv_yaw),
      .m_valid(m_valid), .m_ready(m_ready),
      .m_roll(m_roll), .m_pitch(m_pitch), .m_yaw(m_yaw), .m_src(m_src),
`ifdef CONV_STATS_EN
      .conv_count(conv_count), .timeout_count(timeout_count),
`endif
      .busy(busy), .timeout_err(timeout_err)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   // stimulus controls
   bit           pend0, pend1;
   logic [127:0] q0, q1;
   int           refill;      // 0 manual, 1 always re-raise, 2 random
   int           lat_mode;    // >0 fixed, 0 random 1..8, -1 never, -2 random 1..9 or never
   int           rdy_mode;    // 0 low, 1 high, 2 random
   bit           stray_en;
   bit           use_fixed;
   logic [31:0]  fixed_ang;
   int           done_at;

   // reference model: the in-flight sample described by event timestamps
   bit           md_inflight;
   int           md_hs, md_done;
   bit           md_last, md_src;
   logic [127:0] md_quat;
   logic [95:0]  md_ang;
   int           md_cc, md_tc;

   // event logs (values observed from the DUT, checked against literals)
   int hs_log[$], hs_src_log[$], start_log[$], start_w_log[$];
   int mv_rise_log[$], out_src_log[$], out_roll_log[$], tout_log[$];
   logic prev_mv;

   task automatic chkb(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s cycle %0d: got %0h, required %0h", name, cyc, act, exp);
      end
   endtask

   task automatic chkw(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s cycle %0d: got %0h, required %0h", name, cyc, act, exp);
      end
   endtask

   task automatic chki(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s cycle %0d: got %0d, required %0d", name, cyc, act, exp);
      end
   endtask

   function automatic int qget(input int q[$], input int i);
      if (i < q.size()) return q[i];
      return -1;
   endfunction

   function automatic int evcount(input int kind);
      case (kind)
         0: return out_src_log.size();
         1: return tout_log.size();
         2: return hs_log.size();
         3: return mv_rise_log.size();
         4: return start_log.size();
         default: return out_src_log.size() + tout_log.size();
      endcase
   endfunction

   task automatic clear_logs();
      hs_log.delete(); hs_src_log.delete(); start_log.delete(); start_w_log.delete();
      mv_rise_log.delete(); out_src_log.delete(); out_roll_log.delete(); tout_log.delete();
   endtask

   task automatic model_reset();
      md_inflight = 0; md_hs = -100; md_done = -1; md_last = 1'b1; md_src = 1'b0;
      md_quat = '0; md_ang = '0; md_cc = 0; md_tc = 0;
   endtask

   task automatic check_zero(input string pfx);
      chkw({pfx, "_ctrl"}, 128'({s0_ready, s1_ready, conv_start, m_valid, m_src, busy, timeout_err}), '0);
      chkw({pfx, "_conv_quat"}, {conv_w, conv_x, conv_y, conv_z}, '0);
      chkw({pfx, "_m_angles"}, 128'({m_roll, m_pitch, m_yaw}), '0);
`ifdef CONV_STATS_EN
      chkw({pfx, "_stats"}, 128'({conv_count, timeout_count}), '0);
`endif
   endtask

   // Drive this cycle's inputs (called at posedge + 1).
   task automatic drive();
      if (refill == 1) begin
         if (!pend0) begin pend0 = 1; q0 = {$urandom, $urandom, $urandom, $urandom}; end
         if (!pend1) begin pend1 = 1; q1 = {$urandom, $urandom, $urandom, $urandom}; end
      end else if (refill == 2) begin
         if (!pend0 && $urandom_range(0, 3) == 0) begin pend0 = 1; q0 = {$urandom, $urandom, $urandom, $urandom}; end
         if (!pend1 && $urandom_range(0, 3) == 0) begin pend1 = 1; q1 = {$urandom, $urandom, $urandom, $urandom}; end
      end
      s0_valid = pend0; s0_quat = q0;
      s1_valid = pend1; s1_quat = q1;
      conv_done = (cyc == done_at);
      if (!conv_done && stray_en && !(md_inflight && md_done < 0) && $urandom_range(0, 7) == 0)
         conv_done = 1'b1;
      conv_roll = $urandom; conv_pitch = $urandom; conv_yaw = $urandom;
      if (conv_done && use_fixed) begin
         conv_roll = fixed_ang; conv_pitch = fixed_ang; conv_yaw = fixed_ang;
      end
      m_ready = (rdy_mode == 1) || (rdy_mode == 2 && $urandom_range(0, 1) == 1);
   endtask

   // Compare DUT outputs with the model, then advance the model by one cycle.
   task automatic model_step();
      bit g0, g1, e_to, e_mv;
      g0   = !md_inflight && s0_valid && (!s1_valid || md_last);
      g1   = !md_inflight && s1_valid && (!s0_valid || !md_last);
      e_to = md_inflight && md_done < 0 && cyc == md_hs + 1 + T && !conv_done;
      e_mv = md_inflight && md_done >= 0 && cyc > md_done;
      chkb("s0_ready", s0_ready, g0);
      chkb("s1_ready", s1_ready, g1);
      chkb("busy", busy, md_inflight);
      chkb("conv_start", conv_start, md_inflight && cyc == md_hs + 1);
      chkb("timeout_err", timeout_err, e_to);
      chkb("m_valid", m_valid, e_mv);
      chkb("m_src", m_src, md_src);
      chkw("conv_quat", {conv_w, conv_x, conv_y, conv_z}, md_quat);
      chkw("m_angles", 128'({m_roll, m_pitch, m_yaw}), 128'(md_ang));
`ifdef CONV_STATS_EN
      chki("conv_count", int'(conv_count), md_cc);
      chki("timeout_count", int'(timeout_count), md_tc);
`endif
      if (md_inflight) begin
         if (md_done < 0 && conv_done && cyc >= md_hs + 2 && cyc <= md_hs + 1 + T) begin
            md_done = cyc;
            md_ang  = {conv_roll, conv_pitch, conv_yaw};
            if (md_cc < 65535) md_cc++;
         end else if (e_to) begin
            md_inflight = 0;
            if (md_tc < 65535) md_tc++;
         end else if (e_mv && m_ready) begin
            md_inflight = 0;
         end
      end else if (g0 || g1) begin
         md_inflight = 1; md_hs = cyc; md_done = -1;
         md_last = g1; md_src = g1;
         md_quat = g1 ? s1_quat : s0_quat;
      end
   endtask

   // Observe the cycle (called at negedge): producers, converter, logs, model.
   task automatic sample();
      int r;
      if (rst_n) begin
         if ((s0_valid && s0_ready) || (s1_valid && s1_ready)) begin
            hs_log.push_back(cyc);
            hs_src_log.push_back((s1_valid && s1_ready) ? 1 : 0);
         end
         if (s0_valid && s0_ready) pend0 = 0;
         if (s1_valid && s1_ready) pend1 = 0;
         if (conv_start) begin
            start_log.push_back(cyc);
            start_w_log.push_back(int'(conv_w));
            if (lat_mode > 0) done_at = cyc + lat_mode;
            else if (lat_mode == 0) done_at = cyc + int'($urandom_range(1, 8));
            else if (lat_mode == -2) begin
               r = int'($urandom_range(1, 10));
               if (r <= 9) done_at = cyc + r;
            end
         end
         if (m_valid && !prev_mv) mv_rise_log.push_back(cyc);
         if (m_valid && m_ready) begin
            out_src_log.push_back(m_src ? 1 : 0);
            out_roll_log.push_back(int'(m_roll));
         end
         if (timeout_err) tout_log.push_back(cyc);
         model_step();
      end
      prev_mv = m_valid;
   endtask

   task automatic step();
      drive();
      @(negedge clk);
      sample();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run_until(input int kind, input int n, input int budget, input string name);
      int k = 0;
      while (evcount(kind) < n && k < budget) begin
         step();
         k++;
      end
      chkb({name, "_reached"}, evcount(kind) >= n, 1'b1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      pend0 = 0; pend1 = 0; s0_valid = 0; s1_valid = 0;
      m_ready = 0; conv_done = 0; done_at = -1;
      refill = 0; stray_en = 0; use_fixed = 0; rdy_mode = 1; lat_mode = 2;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      cyc++;
      check_zero("reset");
      rst_n = 1'b1;
      prev_mv = 1'b0;
      clear_logs();
   endtask

   initial begin
      int c0;
      rst_n = 1'b0;
      s0_quat = '0; s1_quat = '0; q0 = '0; q1 = '0;
      conv_roll = '0; conv_pitch = '0; conv_yaw = '0; fixed_ang = '0;

      // 1: single source-0 sample through a 3-cycle converter
      do_reset();
      lat_mode = 3; use_fixed = 1; fixed_ang = 32'h0; rdy_mode = 1;
      pend0 = 1; q0 = {32'h4000_0000, 96'h0};
      c0 = cyc;
      run_until(0, 1, 50, "t1_result");
      chki("t1_ready_cycle", qget(hs_log, 0), c0);
      chki("t1_start_cycle", qget(start_log, 0), c0 + 1);
      chki("t1_conv_w", qget(start_w_log, 0), 32'h4000_0000);
      chki("t1_mvalid_cycle", qget(mv_rise_log, 0), c0 + 1 + 3 + 1);
      chki("t1_m_src", qget(out_src_log, 0), 0);
      chki("t1_m_roll", qget(out_roll_log, 0), 0);

      // 2: both sources always valid -> strict alternation from source 0
      do_reset();
      refill = 1; lat_mode = 0; rdy_mode = 1;
      run_until(0, 4, 200, "t2_results");
      for (int i = 0; i < 4; i++) chki($sformatf("t2_src%0d", i), qget(out_src_log, i), i % 2);

      // 3: converter never answers -> one timeout, then s1 accepted; then done on the timeout cycle
      do_reset();
      lat_mode = -1; rdy_mode = 1;
      pend0 = 1; q0 = {$urandom, $urandom, $urandom, $urandom};
      run_until(1, 1, 50, "t3_timeout");
      chki("t3_tout_delay", qget(tout_log, 0) - qget(start_log, 0), 8);
      repeat (5) step();
      chki("t3_tout_once", tout_log.size(), 1);
      chki("t3_no_mvalid", mv_rise_log.size(), 0);
      lat_mode = 2;
      pend1 = 1; q1 = {$urandom, $urandom, $urandom, $urandom};
      run_until(0, 1, 50, "t3_next");
      chki("t3_next_src", qget(hs_src_log, 1), 1);
      chki("t3_out_src", qget(out_src_log, 0), 1);
      lat_mode = T;
      pend0 = 1; q0 = {$urandom, $urandom, $urandom, $urandom};
      run_until(0, 2, 60, "t3_edge");
      chki("t3_edge_no_tout", tout_log.size(), 1);
      chki("t3_edge_src", qget(out_src_log, 1), 0);

      // 4: consumer stalls 10 cycles with both sources waiting
      do_reset();
      lat_mode = 2; use_fixed = 1; fixed_ang = 32'h005A_0000; rdy_mode = 0;
      pend0 = 1; q0 = {$urandom, $urandom, $urandom, $urandom};
      pend1 = 1; q1 = {$urandom, $urandom, $urandom, $urandom};
      run_until(3, 1, 50, "t4_result");
      for (int i = 0; i < 10; i++) begin
         step();
         chkb("t4_hold_valid", m_valid, 1'b1);
         chkw("t4_hold_roll", 128'(m_roll), 128'(32'h005A_0000));
         chkb("t4_s0_ready", s0_ready, 1'b0);
         chkb("t4_s1_ready", s1_ready, 1'b0);
      end
      rdy_mode = 1;
      step();
      rdy_mode = 0;
      chkb("t4_mvalid_drop", m_valid, 1'b0);
      chkw("t4_roll_kept", 128'(m_roll), 128'(32'h005A_0000));

      // 5: reset while waiting on the converter
      do_reset();
      lat_mode = -1; rdy_mode = 1;
      pend0 = 1; q0 = {$urandom, $urandom, $urandom, $urandom};
      run_until(4, 1, 50, "t5_start");
      step(); step();
      chkb("t5_busy_before", busy, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check_zero("t5_async");
      model_reset();
      @(posedge clk); #1; cyc++;
      step();
      rst_n = 1'b1;
      clear_logs();
      done_at = cyc + 1;
      repeat (4) step();
      chki("t5_no_mvalid", mv_rise_log.size(), 0);
      pend0 = 1; q0 = {$urandom, $urandom, $urandom, $urandom};
      pend1 = 1; q1 = {$urandom, $urandom, $urandom, $urandom};
      run_until(2, 1, 20, "t5_grant");
      chki("t5_first_grant", qget(hs_src_log, 0), 0);

`ifdef CONV_STATS_EN
      // 6: three conversions and two timeouts
      do_reset();
      rdy_mode = 1;
      for (int i = 0; i < 5; i++) begin
         lat_mode = (i == 1 || i == 3) ? -1 : 2;
         pend0 = 1; q0 = {$urandom, $urandom, $urandom, $urandom};
         run_until(5, i + 1, 60, "t6_event");
      end
      repeat (2) step();
      chki("t6_conv_count", int'(conv_count), 3);
      chki("t6_timeout_count", int'(timeout_count), 2);
`endif

      // 7: randomized traffic, stalls, late/missing dones and stray dones
      do_reset();
      refill = 2; lat_mode = -2; rdy_mode = 2; stray_en = 1;
      repeat (3000) step();
      chkb("t7_activity", out_src_log.size() > 50, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
